// File: rtl/int_sources_pkg.sv
// Shared constants and types for the interrupt source block: source indices,
// control-register bit positions and the default timer divider.
package int_pkg;

  localparam int unsigned NUM_SRC   = 3;
  localparam int unsigned SRC_TIMER = 0;
  localparam int unsigned SRC_EXTA  = 1;
  localparam int unsigned SRC_EXTB  = 2;

  localparam int unsigned CTL_TEN     = 0;
  localparam int unsigned CTL_POLA    = 1;
  localparam int unsigned CTL_POLB    = 2;
  localparam int unsigned CTL_RESTART = 4;

  localparam logic [15:0] DIV_RESET_DEFAULT = 16'd532;

  // Stored part of the control register; field order matches the CTL_* bit positions.
  typedef struct packed {
    logic rsvd;
    logic polb;
    logic pola;
    logic ten;
  } ctl_t;

  localparam ctl_t CTL_RESET = '{rsvd: 1'b0, polb: 1'b0, pola: 1'b0, ten: 1'b1};

  function automatic logic [7:0] ctl_readback(input logic warm, input ctl_t ctl);
    return {3'b000, warm, ctl};
  endfunction

endpackage

// File: rtl/int_sources_if.sv
// CPU register-port bundle between the port decoder (master) and int_sources (slave).
interface int_sources_if;

  logic [7:0] din;
  logic       div_lo_wr;
  logic       div_hi_wr;
  logic       ctl_wr;
  logic [7:0] ctl_rd;

  modport master (
    output din,
    output div_lo_wr,
    output div_hi_wr,
    output ctl_wr,
    input  ctl_rd
  );

  modport slave (
    input  din,
    input  div_lo_wr,
    input  div_hi_wr,
    input  ctl_wr,
    output ctl_rd
  );

endinterface

// File: rtl/int_sources_edge_sync.sv
// Synchroniser chain plus history flop producing a registered, gated,
// polarity-selected single-cycle edge strobe for one asynchronous line.
module edge_sync #(
  parameter int unsigned SyncStages = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic line_i,
  input  logic pol_i,
  input  logic gate_i,
  output logic stb_o
);

  logic [SyncStages-1:0] sync_q;
  logic                  hist_q;
  logic                  stb_q;
  logic                  sync_out;
  logic                  edge_det;

  assign sync_out = sync_q[SyncStages-1];

  // Only the synchronised level versus its history matters, so a polarity
  // change alone never produces an edge.
  always_comb begin
    edge_det = (sync_out != hist_q) && (sync_out == pol_i);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '1;
      hist_q <= 1'b1;
      stb_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SyncStages-2:0], line_i};
      hist_q <= sync_out;
      stb_q  <= edge_det & gate_i;
    end
  end

  assign stb_o = stb_q;

endmodule

// File: rtl/int_sources.sv
// Interrupt request sources for the Z80 interrupt controller: a programmable
// periodic timer (source 0) and two edge-detected external lines (sources 1, 2).
module int_sources
  import int_pkg::*;
#(
  parameter logic [15:0] DIV_RESET   = DIV_RESET_DEFAULT,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst,
  int_sources_if.slave       bus,
  input  logic               ext_a,
  input  logic               ext_b,
  output logic [NUM_SRC-1:0] int_stbs
);

  ctl_t        ctl_q, ctl_d;
  logic [15:0] div_q, div_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  shadow_q, shadow_d;
  logic [1:0]  warm_q, warm_d;
  logic        tmr_stb_q, tmr_stb_d;
  logic        warm;
  logic        restart;
  logic        ten_rise;
  logic        ext_stb_a;
  logic        ext_stb_b;

  assign warm = (warm_q == 2'd3);

  always_comb begin
    shadow_d = bus.div_lo_wr ? bus.din : shadow_q;
    div_d    = bus.div_hi_wr ? {bus.din, shadow_q} : div_q;
    ctl_d    = bus.ctl_wr ? ctl_t'(bus.din[3:0]) : ctl_q;
    warm_d   = warm ? warm_q : warm_q + 2'd1;

    restart  = bus.ctl_wr && bus.din[CTL_RESTART];
    ten_rise = bus.ctl_wr && bus.din[CTL_TEN] && !ctl_q.ten;

    cnt_d     = cnt_q;
    tmr_stb_d = 1'b0;
    // Reloads use div_d so a same-cycle high-byte write takes effect at once.
    if (restart || ten_rise) begin
      cnt_d = div_d;
    end else if (ctl_q.ten) begin
      if (cnt_q == 16'd0) begin
        cnt_d     = div_d;
        tmr_stb_d = 1'b1;
      end else begin
        cnt_d = cnt_q - 16'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctl_q     <= CTL_RESET;
      div_q     <= DIV_RESET;
      cnt_q     <= DIV_RESET;
      shadow_q  <= 8'h00;
      warm_q    <= 2'd0;
      tmr_stb_q <= 1'b0;
    end else begin
      ctl_q     <= ctl_d;
      div_q     <= div_d;
      cnt_q     <= cnt_d;
      shadow_q  <= shadow_d;
      warm_q    <= warm_d;
      tmr_stb_q <= tmr_stb_d;
    end
  end

  edge_sync #(
    .SyncStages (SYNC_STAGES)
  ) u_ext_a (
    .clk_i  (clk),
    .rst_i  (rst),
    .line_i (ext_a),
    .pol_i  (ctl_q.pola),
    .gate_i (warm),
    .stb_o  (ext_stb_a)
  );

  edge_sync #(
    .SyncStages (SYNC_STAGES)
  ) u_ext_b (
    .clk_i  (clk),
    .rst_i  (rst),
    .line_i (ext_b),
    .pol_i  (ctl_q.polb),
    .gate_i (warm),
    .stb_o  (ext_stb_b)
  );

  always_comb begin
    int_stbs            = '0;
    int_stbs[SRC_TIMER] = tmr_stb_q;
    int_stbs[SRC_EXTA]  = ext_stb_a;
    int_stbs[SRC_EXTB]  = ext_stb_b;
  end

  assign bus.ctl_rd = ctl_readback(warm, ctl_q);

endmodule

// File: tb/tb_int_sources.sv
// Scoreboard bench for int_sources: expected strobe cycles are queued per source
// when stimulus is driven and matched against the strobes as they appear.
module tb_int_sources;

  logic       clk;
  logic       rst;
  logic       ext_a;
  logic       ext_b;
  logic [2:0] int_stbs;
  int         cyc;
  int         n_tot;
  int         n_bad;
  int         exp_q[3][$];

  int_sources_if bus_if ();

  int_sources u_dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus_if),
    .ext_a    (ext_a),
    .ext_b    (ext_b),
    .int_stbs (int_stbs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_tot++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", tag, obs, exp_v, cyc);
    end
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // kind: 0 = div_lo_wr, 1 = div_hi_wr, 2 = ctl_wr; called and returns at a negedge.
  task automatic bus_wr(input int kind, input logic [7:0] d);
    bus_if.din       = d;
    bus_if.div_lo_wr = (kind == 0);
    bus_if.div_hi_wr = (kind == 1);
    bus_if.ctl_wr    = (kind == 2);
    @(negedge clk);
    bus_if.div_lo_wr = 1'b0;
    bus_if.div_hi_wr = 1'b0;
    bus_if.ctl_wr    = 1'b0;
    bus_if.din       = 8'h00;
  endtask

  // Monitor: every strobe must match the oldest queued cycle for its source.
  always @(negedge clk) begin
    for (int s = 0; s < 3; s++) begin
      while (exp_q[s].size() > 0 && exp_q[s][0] < cyc) begin
        chk($sformatf("missing_stb%0d", s), 0, 1);
        void'(exp_q[s].pop_front());
      end
      if (int_stbs[s]) begin
        if (exp_q[s].size() == 0) chk($sformatf("spurious_stb%0d", s), 1, 0);
        else chk($sformatf("stb%0d_cycle", s), cyc, exp_q[s].pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int r, r2, e, f, x;
    n_tot = 0;
    n_bad = 0;
    rst = 1'b1;
    ext_a = 1'b1;
    ext_b = 1'b0;  // held low through reset release
    bus_if.din = 8'h00;
    bus_if.div_lo_wr = 1'b0;
    bus_if.div_hi_wr = 1'b0;
    bus_if.ctl_wr = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_stbs", int_stbs, 3'b000);
    chk("rst_ctl_rd", bus_if.ctl_rd, 8'h01);
    rst = 1'b0;
    r = cyc;

    // Default timer: first pulse 533 clocks after release, then every 533.
    exp_q[0].push_back(r + 533);
    exp_q[0].push_back(r + 1066);
    wait_until(r + 2);
    chk("warm_not_yet", bus_if.ctl_rd, 8'h01);
    wait_until(r + 3);
    chk("warm_done", bus_if.ctl_rd, 8'h11);

    // DIV=4 written mid-period: current period unchanged, then period 5.
    wait_until(r + 1100);
    bus_wr(0, 8'h04);
    bus_wr(1, 8'h00);
    chk("ctl_rd_after_div", bus_if.ctl_rd, 8'h11);
    exp_q[0].push_back(r + 1599);
    exp_q[0].push_back(r + 1604);
    exp_q[0].push_back(r + 1609);
    exp_q[0].push_back(r + 1614);

    // Restart in the cycle where cnt==0: suppresses that pulse, next DIV+1 later.
    wait_until(r + 1618);
    exp_q[0].push_back(r + 1624);
    exp_q[0].push_back(r + 1629);
    bus_wr(2, 8'h11);
    wait_until(r + 1630);
    bus_wr(2, 8'h08);  // timer off, reserved bit set, both polarities falling
    chk("ctl_rd_rsvd", bus_if.ctl_rd, 8'h18);
    wait_until(r + 1700);

    // ext_a falling (pol=0): pulse 3 clocks later; rising ignored.
    e = cyc;
    ext_a = 1'b0;
    exp_q[1].push_back(e + 3);
    repeat (10) @(negedge clk);
    ext_a = 1'b1;
    repeat (10) @(negedge clk);
    bus_wr(2, 8'h0A);
    chk("ctl_rd_pola", bus_if.ctl_rd, 8'h1A);
    repeat (5) @(negedge clk);
    ext_a = 1'b0;
    repeat (10) @(negedge clk);
    e = cyc;
    ext_a = 1'b1;
    exp_q[1].push_back(e + 3);
    repeat (10) @(negedge clk);

    // ext_b, polarity falling: rising ignored, falling pulses, 2-clock pulse kept.
    ext_b = 1'b1;
    repeat (10) @(negedge clk);
    e = cyc;
    ext_b = 1'b0;
    exp_q[2].push_back(e + 3);
    repeat (10) @(negedge clk);
    ext_b = 1'b1;
    repeat (2) @(negedge clk);
    x = cyc;
    ext_b = 1'b0;
    exp_q[2].push_back(x + 3);
    repeat (10) @(negedge clk);
    ext_b = 1'b1;
    repeat (10) @(negedge clk);

    // All three sources aligned on one cycle.
    bus_wr(2, 8'h06);
    chk("ctl_rd_polab", bus_if.ctl_rd, 8'h16);
    ext_a = 1'b0;
    ext_b = 1'b0;
    repeat (10) @(negedge clk);
    f = cyc;
    exp_q[0].push_back(f + 6);
    exp_q[0].push_back(f + 11);
    exp_q[0].push_back(f + 16);
    bus_wr(2, 8'h17);
    chk("ctl_rd_no_restart", bus_if.ctl_rd, 8'h17);
    wait_until(f + 3);
    ext_a = 1'b1;
    ext_b = 1'b1;
    exp_q[1].push_back(f + 6);
    exp_q[2].push_back(f + 6);
    wait_until(f + 6);
    chk("all_three", int_stbs, 3'b111);

    // Asynchronous reset while a timer strobe is visible.
    wait_until(f + 16);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_stbs", int_stbs, 3'b000);
    chk("midrst_ctl_rd", bus_if.ctl_rd, 8'h01);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    r2 = cyc;
    exp_q[0].push_back(r2 + 533);
    wait_until(r2 + 540);

    for (int s = 0; s < 3; s++) chk($sformatf("leftover%0d", s), exp_q[s].size(), 0);
    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
